// File: rtl/rgb_pkg.sv
// Shared constants and duty-triple type for the RGB LED PWM path.
// The upstream colour-wheel sequencer imports this package too.
package rgb_pkg;

  localparam int PWM_PERIOD = 1000;
  localparam int DUTY_W     = $clog2(PWM_PERIOD + 1);

  // On-board LED pins are active-low.
  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_duty_t;

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM output: compares the shared period counter with this channel's
// active duty and registers the result onto the pin.
module pwm_channel
  import rgb_pkg::*;
#(
  parameter int DUTY_W     = 10,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] cnt,
  input  logic [DUTY_W-1:0] duty,
  output logic              pin
);

  localparam logic PIN_ON  = ACTIVE_LOW ? LED_ON : LED_OFF;
  localparam logic PIN_OFF = ~PIN_ON;

  // Registered so the pin never glitches on compare-path settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin <= PIN_OFF;
    end else begin
      pin <= (en && (cnt < duty)) ? PIN_ON : PIN_OFF;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver with double-buffered duties: a triple accepted over
// valid/ready sits in the shadow register until the next period boundary.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PERIOD     = PWM_PERIOD,
  parameter int DUTY_W     = $clog2(PERIOD + 1),
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty_r,
  input  logic [DUTY_W-1:0] duty_g,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              RGB_R,
  output logic              RGB_G,
  output logic              RGB_B,
  output logic              period_start
);

  localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD - 1);

  // Same layout as rgb_duty_t, but sized by this instance's DUTY_W.
  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } duty_t;

  function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] x);
    return (x > PERIOD_V) ? PERIOD_V : x;
  endfunction

  logic [DUTY_W-1:0] cnt;
  duty_t             shadow;
  duty_t             active;
  logic              pending;
  logic              wrap;
  logic              accept;

  assign wrap       = en && (cnt == LAST_CNT);
  assign duty_ready = !pending;
  assign accept     = duty_valid && duty_ready;

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain cnt -> wrap within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  // Apply and accept are exclusive: apply needs pending=1, accept needs 0.
  // An accept on the wrap edge therefore waits a full period to apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (wrap && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= '{r: clamp(duty_r), g: clamp(duty_g), b: clamp(duty_b)};
      pending <= 1'b1;
    end
  end

  pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .duty(active.r), .pin(RGB_R)
  );

  pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .duty(active.g), .pin(RGB_G)
  );

  pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .duty(active.b), .pin(RGB_B)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at PERIOD=10, active-low pins.
// Observations are taken 1 time unit after each rising edge.
module tb_rgb_pwm_driver;

  localparam int PERIOD = 10;
  localparam int DUTY_W = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic              duty_valid;
  logic              duty_ready;
  logic              RGB_R;
  logic              RGB_G;
  logic              RGB_B;
  logic              period_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Each entry: {RGB_R, RGB_G, RGB_B, period_start, duty_ready}.
  logic [4:0] obs [0:PERIOD-1];
  logic [4:0] expv;

  rgb_pwm_driver #(.PERIOD(PERIOD), .DUTY_W(DUTY_W), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      obs[i] = {RGB_R, RGB_G, RGB_B, period_start, duty_ready};
    end
  endtask

  task automatic send(input int r, input int g, input int b);
    duty_r     = DUTY_W'(r);
    duty_g     = DUTY_W'(g);
    duty_b     = DUTY_W'(b);
    duty_valid = 1'b1;
  endtask

  // Observation after the edge that left cnt=k: pins reflect (k < duty),
  // period_start is high only after the wrap edge (k==9).
  function automatic logic [4:0] exp_obs(input int k, input int dr, input int dg,
                                         input int db, input logic rdy);
    return {(k < dr) ? 1'b0 : 1'b1, (k < dg) ? 1'b0 : 1'b1,
            (k < db) ? 1'b0 : 1'b1, (k == PERIOD - 1) ? 1'b1 : 1'b0, rdy};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    send(7, 7, 7);
    step();
    step();
    n_tests++;
    if ({RGB_R, RGB_G, RGB_B, period_start} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 1110", {RGB_R, RGB_G, RGB_B, period_start});
    end
    n_tests++;
    if (duty_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", duty_ready);
    end
    duty_valid = 1'b0;
    rst_n      = 1'b1;
    run_cycles(PERIOD);
    for (int i = 0; i < PERIOD; i++) begin
      expv = exp_obs(i, 0, 0, 0, 1'b1);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL reset_no_accept cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
  endtask

  task automatic test_basic_load();
    send(3, 0, 10);
    run_cycles(1);
    duty_valid = 1'b0;
    expv = exp_obs(0, 0, 0, 0, 1'b0);
    n_tests++;
    if (obs[0] !== expv) begin
      n_fail++;
      $display("FAIL basic_accept: got %b want %b", obs[0], expv);
    end
    run_cycles(PERIOD - 1);
    for (int i = 0; i < PERIOD - 1; i++) begin
      expv = exp_obs(i + 1, 0, 0, 0, i == PERIOD - 2);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL basic_wait cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
    for (int p = 0; p < 2; p++) begin
      run_cycles(PERIOD);
      for (int i = 0; i < PERIOD; i++) begin
        expv = exp_obs(i, 3, 0, 10, 1'b1);
        n_tests++;
        if (obs[i] !== expv) begin
          n_fail++;
          $display("FAIL basic_period%0d cyc%0d: got %b want %b", p, i, obs[i], expv);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    send(5, 5, 5);
    run_cycles(1);
    send(2, 2, 2);
    expv = exp_obs(0, 3, 0, 10, 1'b0);
    n_tests++;
    if (obs[0] !== expv) begin
      n_fail++;
      $display("FAIL bp_first_accept: got %b want %b", obs[0], expv);
    end
    run_cycles(PERIOD - 1);
    for (int i = 0; i < PERIOD - 1; i++) begin
      expv = exp_obs(i + 1, 3, 0, 10, i == PERIOD - 2);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL bp_held cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
    run_cycles(1);
    duty_valid = 1'b0;
    expv = exp_obs(0, 5, 5, 5, 1'b0);
    n_tests++;
    if (obs[0] !== expv) begin
      n_fail++;
      $display("FAIL bp_second_accept: got %b want %b", obs[0], expv);
    end
    run_cycles(PERIOD - 1);
    for (int i = 0; i < PERIOD - 1; i++) begin
      expv = exp_obs(i + 1, 5, 5, 5, i == PERIOD - 2);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL bp_555 cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
    run_cycles(PERIOD);
    for (int i = 0; i < PERIOD; i++) begin
      expv = exp_obs(i, 2, 2, 2, 1'b1);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL bp_222 cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
  endtask

  task automatic test_clamp();
    send(15, 0, 10);
    run_cycles(1);
    duty_valid = 1'b0;
    run_cycles(PERIOD - 1);
    for (int i = 0; i < PERIOD - 1; i++) begin
      expv = exp_obs(i + 1, 2, 2, 2, i == PERIOD - 2);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL clamp_wait cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
    for (int p = 0; p < 2; p++) begin
      run_cycles(PERIOD);
      for (int i = 0; i < PERIOD; i++) begin
        expv = exp_obs(i, PERIOD, 0, PERIOD, 1'b1);
        n_tests++;
        if (obs[i] !== expv) begin
          n_fail++;
          $display("FAIL clamp_period%0d cyc%0d: got %b want %b", p, i, obs[i], expv);
        end
      end
    end
  endtask

  task automatic test_coincident();
    run_cycles(PERIOD - 1);
    send(4, 6, 1);
    run_cycles(1);
    duty_valid = 1'b0;
    expv = exp_obs(PERIOD - 1, PERIOD, 0, PERIOD, 1'b0);
    n_tests++;
    if (obs[0] !== expv) begin
      n_fail++;
      $display("FAIL coinc_accept: got %b want %b", obs[0], expv);
    end
    run_cycles(PERIOD);
    for (int i = 0; i < PERIOD; i++) begin
      expv = exp_obs(i, PERIOD, 0, PERIOD, i == PERIOD - 1);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL coinc_old cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
    run_cycles(PERIOD);
    for (int i = 0; i < PERIOD; i++) begin
      expv = exp_obs(i, 4, 6, 1, 1'b1);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL coinc_new cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
  endtask

  task automatic test_enable();
    run_cycles(4);
    en = 1'b0;
    run_cycles(1);
    n_tests++;
    if (obs[0] !== 5'b11101) begin
      n_fail++;
      $display("FAIL en_off: got %b want 11101", obs[0]);
    end
    send(1, 1, 1);
    run_cycles(1);
    duty_valid = 1'b0;
    run_cycles(3);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs[i] !== 5'b11100) begin
        n_fail++;
        $display("FAIL en_off_pending cyc%0d: got %b want 11100", i, obs[i]);
      end
    end
    en = 1'b1;
    run_cycles(PERIOD);
    for (int i = 0; i < PERIOD; i++) begin
      expv = exp_obs(i, 4, 6, 1, i == PERIOD - 1);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL en_restart cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
    run_cycles(PERIOD);
    for (int i = 0; i < PERIOD; i++) begin
      expv = exp_obs(i, 1, 1, 1, 1'b1);
      n_tests++;
      if (obs[i] !== expv) begin
        n_fail++;
        $display("FAIL en_pending_applied cyc%0d: got %b want %b", i, obs[i], expv);
      end
    end
  endtask

  task automatic test_async_reset();
    run_cycles(6);
    send(8, 8, 8);
    run_cycles(1);
    duty_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({RGB_R, RGB_G, RGB_B, period_start, duty_ready} !== 5'b11101) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 11101",
               {RGB_R, RGB_G, RGB_B, period_start, duty_ready});
    end
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      run_cycles(PERIOD);
      for (int i = 0; i < PERIOD; i++) begin
        expv = exp_obs(i, 0, 0, 0, 1'b1);
        n_tests++;
        if (obs[i] !== expv) begin
          n_fail++;
          $display("FAIL post_reset%0d cyc%0d: got %b want %b", p, i, obs[i], expv);
        end
      end
    end
  endtask

  initial begin
    duty_valid = 1'b0;
    duty_r     = '0;
    duty_g     = '0;
    duty_b     = '0;
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_clamp();
    test_coincident();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
